// File: rtl/matmul_pkg.sv
// Shared operand parameters for the matmul A/B buffers and their loaders.
package matmul_pkg;

  // Element widths and chunking shared by both operands
  localparam int WIDTH_A       = 16;
  localparam int WIDTH_B       = 16;
  localparam int CHUNK_SIZE_AB = 4;

  // Core counts: how many chunks each BRAM word carries
  localparam int NUM_CORES_A = 4;
  localparam int NUM_CORES_B = 1;

  // Operand shapes
  localparam int OUTER_DIM_A = 6;
  localparam int OUTER_DIM_B = 6;
  localparam int INNER_DIM   = 64;

  // Buffer geometry derived from the shapes above
  localparam int DEPTH_A      = INNER_DIM * OUTER_DIM_A / (CHUNK_SIZE_AB * NUM_CORES_A);
  localparam int DEPTH_B      = INNER_DIM * OUTER_DIM_B / (CHUNK_SIZE_AB * NUM_CORES_B);
  localparam int ADDR_WIDTH_A = $clog2(DEPTH_A);
  localparam int ADDR_WIDTH_B = $clog2(DEPTH_B);
  localparam int WORD_WIDTH_A = WIDTH_A * CHUNK_SIZE_AB * NUM_CORES_A;
  localparam int WORD_WIDTH_B = WIDTH_B * CHUNK_SIZE_AB * NUM_CORES_B;

  // Counter width that stays legal when only one beat makes a word
  function automatic int beat_cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matmul_bram_loader_chunk_packer.sv
// Collects NUM_CORES input chunks into one BRAM word. The word output is the
// pack register with the current beat already merged in, so the caller can
// register it on the same edge that accepts the last beat of the word.
module chunk_packer
  import matmul_pkg::*;
#(
  parameter int WIDTH      = WIDTH_A,
  parameter int CHUNK_SIZE = CHUNK_SIZE_AB,
  parameter int NUM_CORES  = NUM_CORES_A
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clear,
  input  logic                                  beat_valid,
  input  logic [WIDTH*CHUNK_SIZE-1:0]           beat_data,
  output logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] word,
  output logic                                  word_valid
);

  localparam int CW = WIDTH * CHUNK_SIZE;
  localparam int WW = CW * NUM_CORES;
  localparam int BW = beat_cnt_width(NUM_CORES);
  localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_CORES - 1);

  logic [BW-1:0] beat_cnt;
  logic [WW-1:0] pack_q;

  // Merge the incoming chunk into its slot so a completing beat yields the full word
  always_comb begin
    word                       = pack_q;
    word[beat_cnt*CW +: CW]    = beat_data;
    word_valid                 = beat_valid && (beat_cnt == LAST_BEAT);
  end

  // Beat position within the word and storage of the partial word
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      pack_q   <= '0;
    end else if (clear) begin
      beat_cnt <= '0;
    end else if (beat_valid) begin
      pack_q[beat_cnt*CW +: CW] <= beat_data;
      beat_cnt                  <= word_valid ? '0 : beat_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/matmul_bram_loader.sv
// Stream-to-BRAM writer for one matmul operand buffer. Packs NUM_CORES chunks
// per word and writes words to sequential addresses from 0.
//
// Stream handshake: a beat transfers on a rising edge where s_valid and
// s_ready are both high; s_ready is high exactly while in LOAD, and the
// source may hold s_valid low for any number of cycles without loss.
module matmul_bram_loader
  import matmul_pkg::*;
#(
  parameter int WIDTH           = WIDTH_A,
  parameter int CHUNK_SIZE      = CHUNK_SIZE_AB,
  parameter int NUM_CORES       = NUM_CORES_A,
  parameter int OUTER_DIMENSION = OUTER_DIM_A,
  parameter int INNER_DIMENSION = INNER_DIM,
  parameter int DEPTH           = INNER_DIMENSION * OUTER_DIMENSION / (CHUNK_SIZE * NUM_CORES),
  parameter int ADDR_WIDTH      = $clog2(DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic [WIDTH*CHUNK_SIZE-1:0]           s_data,
  input  logic                                  s_last,
  output logic                                  bram_we,
  output logic [ADDR_WIDTH-1:0]                 bram_addr,
  output logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] bram_wdata,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err_len
);

  localparam int WW = WIDTH * CHUNK_SIZE * NUM_CORES;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] word_cnt;
  logic                  accept;
  logic                  word_valid;
  logic                  final_beat;
  logic [WW-1:0]         word;

  assign accept     = s_valid && s_ready;
  assign final_beat = word_valid && (word_cnt == LAST_ADDR);

  // Packer restarts whenever the loader is idle, which drops any partial word
  chunk_packer #(
    .WIDTH      (WIDTH),
    .CHUNK_SIZE (CHUNK_SIZE),
    .NUM_CORES  (NUM_CORES)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (state == IDLE),
    .beat_valid (accept),
    .beat_data  (s_data),
    .word       (word),
    .word_valid (word_valid)
  );

  // Load FSM with registered handshake, write port and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      word_cnt   <= '0;
      s_ready    <= 1'b0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      bram_we <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            word_cnt <= '0;
            err_len  <= 1'b0;
            s_ready  <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            if (word_valid) begin
              bram_we    <= 1'b1;
              bram_addr  <= word_cnt;
              bram_wdata <= word;
              word_cnt   <= word_cnt + 1'b1;
            end
            if (final_beat || s_last) begin
              // An s_last anywhere but the final beat, or a final beat
              // without s_last, is a length mismatch
              if (final_beat != s_last) err_len <= 1'b1;
              state   <= IDLE;
              s_ready <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_bram_loader.sv
// Bench for matmul_bram_loader: A instance (4 cores) driven from a scenario
// table with a write scoreboard, B instance (1 core) checked beat by beat.
module tb_matmul_bram_loader;

  localparam int AW_A = 5;
  localparam int WW_A = 256;
  localparam int AW_B = 7;
  localparam int WW_B = 64;
  localparam int CW   = 64;
  localparam int EW   = AW_A + WW_A;

  logic clk;
  logic rst;

  logic            start_a, s_valid_a, s_last_a, s_ready_a;
  logic [CW-1:0]   s_data_a;
  logic            bram_we_a, busy_a, done_a, err_len_a;
  logic [AW_A-1:0] bram_addr_a;
  logic [WW_A-1:0] bram_wdata_a;

  logic            start_b, s_valid_b, s_last_b, s_ready_b;
  logic [CW-1:0]   s_data_b;
  logic            bram_we_b, busy_b, done_b, err_len_b;
  logic [AW_B-1:0] bram_addr_b;
  logic [WW_B-1:0] bram_wdata_b;

  matmul_bram_loader dut_a (
    .clk(clk), .rst(rst), .start(start_a), .s_valid(s_valid_a), .s_ready(s_ready_a),
    .s_data(s_data_a), .s_last(s_last_a), .bram_we(bram_we_a), .bram_addr(bram_addr_a),
    .bram_wdata(bram_wdata_a), .busy(busy_a), .done(done_a), .err_len(err_len_a)
  );

  matmul_bram_loader #(.NUM_CORES(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .s_valid(s_valid_b), .s_ready(s_ready_b),
    .s_data(s_data_b), .s_last(s_last_b), .bram_we(bram_we_b), .bram_addr(bram_addr_b),
    .bram_wdata(bram_wdata_b), .busy(busy_b), .done(done_b), .err_len(err_len_b)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [EW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  int            n_cmp;
  int            n_err;
  int            cyc;
  int            writes_seen;

  typedef struct {
    int n_beats;
    int last_at;
    bit gaps;
    int exp_writes;
    bit exp_err;
  } scen_t;

  scen_t scen[7];

  function automatic logic [CW-1:0] chunk_of(input int n);
    logic [CW-1:0] c;
    for (int e = 0; e < 4; e++) c[e*16 +: 16] = 16'(4*n + e);
    return c;
  endfunction

  // Word w holds elements 16w..16w+15 ascending from the LSB
  function automatic logic [WW_A-1:0] word_of(input int w);
    logic [WW_A-1:0] d;
    for (int i = 0; i < 16; i++) d[i*16 +: 16] = 16'(16*w + i);
    return d;
  endfunction

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event not as required (cycle %0d)", name, cyc);
  endtask

  // Write monitor for instance A, run at every falling edge
  task automatic monitor_a();
    logic [EW-1:0] e;
    int c;
    if (bram_we_a) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_write_a");
      end else begin
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        chk("write_a", {bram_addr_a, bram_wdata_a}, e);
        chk("write_latency_a", EW'(cyc), EW'(c));
        writes_seen++;
      end
    end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
      fail_now("missing_write_a");
      void'(exp_q.pop_front());
      void'(exp_cyc_q.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    monitor_a();
  endtask

  // Offer global beat n to A until accepted; predicts the write it completes
  task automatic send_beat_a(input int n, input bit last);
    bit acc;
    s_valid_a = 1'b1;
    s_data_a  = chunk_of(n);
    s_last_a  = last;
    for (int t = 0; t < 20; t++) begin
      acc = s_valid_a && s_ready_a;
      if (acc && (n % 4 == 3)) begin
        exp_q.push_back({AW_A'(n / 4), word_of(n / 4)});
        exp_cyc_q.push_back(cyc + 1);
      end
      tick();
      if (acc) break;
      if (t == 19) fail_now("accept_timeout_a");
    end
    s_valid_a = 1'b0;
    s_last_a  = 1'b0;
  endtask

  task automatic start_load_a();
    chk("ready_before_start_a", EW'(s_ready_a), EW'(0));
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("busy_after_start_a", EW'(busy_a), EW'(1));
    chk("ready_after_start_a", EW'(s_ready_a), EW'(1));
    chk("err_clear_on_start_a", EW'(err_len_a), EW'(0));
  endtask

  task automatic check_all_reset();
    chk("rst_ready_a", EW'(s_ready_a), EW'(0));
    chk("rst_we_a", EW'(bram_we_a), EW'(0));
    chk("rst_addr_data_a", {bram_addr_a, bram_wdata_a}, EW'(0));
    chk("rst_busy_done_err_a", EW'({busy_a, done_a, err_len_a}), EW'(0));
  endtask

  initial begin
    int start_cyc;
    bit prev_err;
    n_cmp = 0; n_err = 0; cyc = 0; writes_seen = 0;
    rst = 1'b1;
    start_a = 0; s_valid_a = 0; s_last_a = 0; s_data_a = '0;
    start_b = 0; s_valid_b = 0; s_last_b = 0; s_data_b = '0;

    //               beats last gaps writes err
    scen[0] = '{96,  95,  0,   24,    0};
    scen[1] = '{96,  95,  1,   24,    0};
    scen[2] = '{42,  41,  0,   10,    1};
    scen[3] = '{96,  -1,  0,   24,    1};
    scen[4] = '{4,   3,   1,   1,     1};
    scen[5] = '{1,   0,   0,   0,     1};
    scen[6] = '{8,   7,   0,   2,     1};

    // Reset state of both instances
    repeat (3) tick();
    check_all_reset();
    chk("rst_b", EW'({s_ready_b, bram_we_b, busy_b, done_b, err_len_b, bram_addr_b}), EW'(0));
    chk("rst_wdata_b", EW'(bram_wdata_b), EW'(0));
    rst = 1'b0;
    tick();

    // Table-driven loads on instance A
    prev_err = 1'b0;
    for (int s = 0; s < 7; s++) begin
      writes_seen = 0;
      chk("err_sticky_idle_a", EW'(err_len_a), EW'(prev_err));
      start_load_a();
      start_cyc = cyc;
      for (int n = 0; n < scen[s].n_beats; n++) begin
        if (scen[s].gaps) begin
          int g;
          g = $urandom_range(0, 2);
          for (int i = 0; i < g; i++) tick();
        end
        send_beat_a(n, n == scen[s].last_at);
      end
      chk("done_pulse_a", EW'(done_a), EW'(1));
      chk("busy_at_done_a", EW'(busy_a), EW'(0));
      chk("ready_at_done_a", EW'(s_ready_a), EW'(0));
      chk("err_len_a", EW'(err_len_a), EW'(scen[s].exp_err));
      if (!scen[s].gaps && scen[s].n_beats == 96)
        chk("load_time_a", EW'(cyc - start_cyc), EW'(96));
      tick();
      chk("done_one_cycle_a", EW'(done_a), EW'(0));
      repeat (2) tick();
      chk("write_count_a", EW'(writes_seen), EW'(scen[s].exp_writes));
      chk("queue_drained_a", EW'(exp_q.size()), EW'(0));
      if (scen[s].exp_writes > 0)
        chk("hold_a", {bram_addr_a, bram_wdata_a},
            {AW_A'(scen[s].exp_writes - 1), word_of(scen[s].exp_writes - 1)});
      prev_err = scen[s].exp_err;
    end

    // Start during LOAD is ignored, then reset after beat 50 aborts the load
    writes_seen = 0;
    start_load_a();
    for (int n = 0; n <= 50; n++) begin
      start_a = (n == 20);
      send_beat_a(n, 1'b0);
      start_a = 1'b0;
    end
    chk("writes_before_rst_a", EW'(writes_seen), EW'(12));
    s_valid_a = 1'b1;
    s_data_a  = chunk_of(51);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("no_resume_after_rst_a", EW'({s_ready_a, done_a, busy_a}), EW'(0));
    end
    s_valid_a = 1'b0;
    chk("writes_after_rst_a", EW'(writes_seen), EW'(12));

    // Instance B: one write per beat, one cycle after acceptance
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("busy_after_start_b", EW'({busy_b, s_ready_b}), EW'(2'b11));
    for (int n = 0; n < 96; n++) begin
      s_valid_b = 1'b1;
      s_data_b  = chunk_of(n);
      s_last_b  = (n == 95);
      tick();
      chk("we_b", EW'(bram_we_b), EW'(1));
      chk("write_b", {bram_addr_b, bram_wdata_b}, {AW_B'(n), chunk_of(n)});
    end
    chk("done_b", EW'({done_b, busy_b, s_ready_b, err_len_b}), EW'(4'b1000));
    s_valid_b = 1'b0;
    s_last_b  = 1'b0;
    tick();
    chk("idle_b", EW'({bram_we_b, done_b}), EW'(0));
    chk("hold_b", {bram_addr_b, bram_wdata_b}, {AW_B'(95), chunk_of(95)});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
